// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared encodings for the unified-memory arbiter: FSM state, transaction
// owner and starvation counter width. Kept in a package so future cache and
// bus blocks decode the same owner values.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch requester, data requester and memory port signals.
//   slave  : arbiter view (requests and mem_rdata in; grants, responses and
//            memory strobes out)
//   master : surrounding core/memory view (opposite directions)
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // fetch requester
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    // data requester
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    // memory port
    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_starve.sv
// mem_arbiter_starve
// Picks the winner between fetch and data. Data normally wins; a saturating
// count of consecutive fetch losses hands the next contested slot to fetch.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   idle_i               arbiter can grant this cycle
//   if_req_i, d_req_i    raw requests
//   win_if_o, win_d_o    winner (at most one set; not gated by idle_i)
module mem_arbiter_starve
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic win_if_o,
    output logic win_d_o
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic                starved;

    assign starved  = (cnt_q == LIMIT);
    assign win_if_o = if_req_i & (~d_req_i | starved);
    assign win_d_o  = d_req_i & ~win_if_o;

    // Only grant cycles move the count; it holds while a transaction is in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (idle_i) begin
            if (!if_req_i || win_if_o)
                cnt_d = '0;
            else if (win_d_o && !starved)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between instruction fetch and data load/store.
// One transaction in flight: grant and mem_en are combinational in IDLE, then
// the FSM waits MEM_LATENCY cycles and pulses the owner's rvalid with
// mem_rdata passed straight through (stores return 0).
// Ports:
//   clk_i   clock
//   rst_ni  async active-low reset; aborts any in-flight transaction
//   bus     mem_arbiter_if.slave: requesters + memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus
);
    localparam int            CW   = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT  = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [XLEN-1:0] ZERO = '0;

    state_e        state_q, state_d;
    owner_e        own_q, own_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic idle, win_if, win_d, grant_if, grant_d, last;

    // Gating with rst_ni keeps every output at 0 while reset is held.
    assign idle     = (state_q == S_IDLE) && rst_ni;
    assign grant_if = idle & win_if;
    assign grant_d  = idle & win_d;
    assign last     = (state_q == S_WAIT) && (cnt_q == ONE);

    mem_arbiter_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .idle_i   (idle),
        .if_req_i (bus.if_req),
        .d_req_i  (bus.d_req),
        .win_if_o (win_if),
        .win_d_o  (win_d)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            own_q   <= OWN_NONE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_if || grant_d) begin
                    state_d = S_WAIT;
                    own_d   = grant_d ? OWN_D : OWN_IF;
                    we_d    = grant_d & bus.d_we;
                    cnt_d   = LAT;
                end
            end
            S_WAIT: begin
                if (last) begin
                    state_d = S_IDLE;
                    own_d   = OWN_NONE;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        bus.if_gnt    = grant_if;
        bus.d_gnt     = grant_d;
        bus.mem_en    = grant_if | grant_d;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = ZERO;
        bus.mem_wdata = ZERO;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = ZERO;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = ZERO;
        if (grant_d) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (grant_if) begin
            bus.mem_addr  = bus.if_addr;
        end
        if (last && own_q == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
        end
        if (last && own_q == OWN_D) begin
            bus.d_rvalid  = 1'b1;
            bus.d_rdata   = we_q ? ZERO : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Two arbiters: A (MEM_LATENCY=1, STARVE_LIMIT=4) driven from a per-cycle
// vector table; B (MEM_LATENCY=3, STARVE_LIMIT=2) driven by hand-written
// sequences for latency, reset abort and starvation ordering.
module tb_mem_arbiter;

    typedef struct packed {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        ig;
        logic        iv;
        logic [31:0] ird;
        logic        dg;
        logic        dv;
        logic [31:0] drd;
        logic        men;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
    } outs_t;

    typedef struct packed {
        in_t   i;
        outs_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(32)) bus_a ();
    mem_arbiter_if #(.XLEN(32)) bus_b ();

    mem_arbiter #(.XLEN(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk_i (clk), .rst_ni (rst_a_n), .bus (bus_a.slave)
    );
    mem_arbiter #(.XLEN(32), .MEM_LATENCY(3), .STARVE_LIMIT(2)) dut_b (
        .clk_i (clk), .rst_ni (rst_b_n), .bus (bus_b.slave)
    );

    outs_t act_a, act_b;
    assign act_a = {bus_a.if_gnt, bus_a.if_rvalid, bus_a.if_rdata, bus_a.d_gnt, bus_a.d_rvalid,
                    bus_a.d_rdata, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata};
    assign act_b = {bus_b.if_gnt, bus_b.if_rvalid, bus_b.if_rdata, bus_b.d_gnt, bus_b.d_rvalid,
                    bus_b.d_rdata, bus_b.mem_en, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata};

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input outs_t act, input outs_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                       input logic ig, input logic iv, input logic [31:0] ird,
                       input logic dg, input logic dv, input logic [31:0] drd,
                       input logic men, input logic mwe, input logic [31:0] maddr,
                       input logic [31:0] mwd);
        vec_t v;
        v.i = '{ifr, ifa, dr, dwe, da, dwd, mrd};
        v.o = '{ig, iv, ird, dg, dv, drd, men, mwe, maddr, mwd};
        tbl.push_back(v);
    endtask

    task automatic drive_b(input logic ifr, input logic [31:0] ifa, input logic dr,
                           input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        bus_b.if_req  = ifr;
        bus_b.if_addr = ifa;
        bus_b.d_req   = dr;
        bus_b.d_we    = dwe;
        bus_b.d_addr  = da;
        bus_b.d_wdata = dwd;
    endtask

    logic got [6];
    logic exp_order [6];
    int   ngnt;

    initial begin
        // Arbiter A, one row per cycle, starting in IDLE with starve count 0.
        //   ifr ifa       dr dwe da       dwd      mrd          ig iv ird          dg dv drd          men mwe maddr    mwd
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'h0,        0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,   32'h0);
        add(1, 32'h100,  0, 0, 32'h0,   32'h0,   32'h0,        1, 0, 32'h0,       0, 0, 32'h0,       1, 0, 32'h100, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,      0, 0, 32'h0,   32'h0);
        add(0, 32'h0,    1, 0, 32'h200, 32'h0,   32'h55,       0, 0, 32'h0,       1, 0, 32'h0,       1, 0, 32'h200, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'hCAFEF00D, 0, 0, 32'h0,       0, 1, 32'hCAFEF00D, 1'b0, 0, 32'h0, 32'h0);
        add(1, 32'h104,  1, 1, 32'h300, 32'hA5A5, 32'h0,       0, 0, 32'h0,       1, 0, 32'h0,       1, 1, 32'h300, 32'hA5A5);
        add(1, 32'h104,  0, 0, 32'h0,   32'h0,   32'h777,      0, 0, 32'h0,       0, 1, 32'h0,       0, 0, 32'h0,   32'h0);
        add(1, 32'h104,  0, 0, 32'h0,   32'h0,   32'h0,        1, 0, 32'h0,       0, 0, 32'h0,       1, 0, 32'h104, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'h12345678, 0, 1, 32'h12345678, 0, 0, 32'h0,      0, 0, 32'h0,   32'h0);
        add(0, 32'h0,    1, 0, 32'h400, 32'h0,   32'h0,        0, 0, 32'h0,       1, 0, 32'h0,       1, 0, 32'h400, 32'h0);
        add(1, 32'h108,  0, 0, 32'h0,   32'h0,   32'h99,       0, 0, 32'h0,       0, 1, 32'h99,      0, 0, 32'h0,   32'h0);
        add(1, 32'h108,  0, 0, 32'h0,   32'h0,   32'h0,        1, 0, 32'h0,       0, 0, 32'h0,       1, 0, 32'h108, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,      0, 0, 32'h0,   32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,   32'hABCD,     0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,   32'h0);

        exp_order = '{0, 0, 1, 0, 0, 1};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
        bus_a.d_addr = 0; bus_a.d_wdata = 0; bus_a.mem_rdata = 0;
        drive_b(0, 0, 0, 0, 0, 0);
        bus_b.mem_rdata = 0;

        repeat (2) @(negedge clk);
        #1;
        chk_outs("reset_a", act_a, '0);
        chk_outs("reset_b", act_b, '0);
        @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // ---- table on A ----
        foreach (tbl[k]) begin
            @(negedge clk);
            bus_a.if_req    = tbl[k].i.ifr;
            bus_a.if_addr   = tbl[k].i.ifa;
            bus_a.d_req     = tbl[k].i.dr;
            bus_a.d_we      = tbl[k].i.dwe;
            bus_a.d_addr    = tbl[k].i.da;
            bus_a.d_wdata   = tbl[k].i.dwd;
            bus_a.mem_rdata = tbl[k].i.mrd;
            #1;
            chk_outs($sformatf("vec_a[%0d]", k), act_a, tbl[k].o);
        end

        // ---- B: store, latency 3, fetch waiting during WAIT ----
        @(negedge clk);
        drive_b(0, 0, 1, 1, 32'h40, 32'h1234);
        #1;
        chk("st_dgnt", 32'(bus_b.d_gnt), 1);
        chk("st_mem_en", 32'(bus_b.mem_en), 1);
        chk("st_mem_we", 32'(bus_b.mem_we), 1);
        chk("st_mem_addr", bus_b.mem_addr, 32'h40);
        chk("st_mem_wdata", bus_b.mem_wdata, 32'h1234);
        @(negedge clk);
        drive_b(1, 32'h200, 0, 0, 0, 0);
        #1;
        chk("wait1_gnt", {30'b0, bus_b.if_gnt, bus_b.mem_en}, 0);
        chk("wait1_rvalid", 32'(bus_b.d_rvalid), 0);
        @(negedge clk);
        #1;
        chk("wait2_gnt", {30'b0, bus_b.if_gnt, bus_b.d_rvalid}, 0);
        @(negedge clk);
        bus_b.mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("st_dvalid", 32'(bus_b.d_rvalid), 1);
        chk("st_drdata", bus_b.d_rdata, 0);
        chk("st_no_if", {30'b0, bus_b.if_gnt, bus_b.if_rvalid}, 0);
        @(negedge clk);
        #1;
        chk("if_after_st_gnt", 32'(bus_b.if_gnt), 1);
        chk("if_after_st_addr", bus_b.mem_addr, 32'h200);
        @(negedge clk);
        drive_b(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus_b.mem_rdata = 32'h600DF00D;
        #1;
        chk("if_b_rvalid", 32'(bus_b.if_rvalid), 1);
        chk("if_b_rdata", bus_b.if_rdata, 32'h600DF00D);

        // ---- B: reset one cycle after grant aborts the load ----
        @(negedge clk);
        drive_b(0, 0, 1, 0, 32'h80, 0);
        #1;
        chk("rst_pre_dgnt", 32'(bus_b.d_gnt), 1);
        @(negedge clk);
        drive_b(0, 0, 0, 0, 0, 0);
        bus_b.mem_rdata = 32'h1111;
        rst_b_n = 1'b0;
        #1;
        chk_outs("rst_mid_outs", act_b, '0);
        @(negedge clk);
        rst_b_n = 1'b1;
        drive_b(1, 32'h500, 0, 0, 0, 0);
        #1;
        chk("rst_post_ifgnt", 32'(bus_b.if_gnt), 1);
        chk("rst_post_addr", bus_b.mem_addr, 32'h500);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_b(0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("rst_no_rvalid[%0d]", c), {30'b0, bus_b.d_rvalid, bus_b.if_rvalid}, 0);
        end
        @(negedge clk);
        bus_b.mem_rdata = 32'h2222;
        #1;
        chk("rst_if_rvalid", {30'b0, bus_b.d_rvalid, bus_b.if_rvalid}, 1);
        chk("rst_if_rdata", bus_b.if_rdata, 32'h2222);

        // ---- B: both held, STARVE_LIMIT=2 -> D D IF D D IF ----
        @(negedge clk);
        drive_b(1, 32'h700, 1, 0, 32'h800, 0);
        ngnt = 0;
        for (int c = 0; c < 60 && ngnt < 6; c++) begin
            #1;
            if (bus_b.if_gnt || bus_b.d_gnt) begin
                got[ngnt] = bus_b.if_gnt;
                ngnt++;
            end
            @(negedge clk);
        end
        drive_b(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++) begin
            if (n < ngnt)
                chk($sformatf("starve_order[%0d]", n), 32'(got[n]), 32'(exp_order[n]));
            else begin
                nchk++;
                nerr++;
                $display("FAIL starve_order[%0d] actual=no_grant expected=grant", n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified memory port between the core's instruction-fetch requester and its data load/store requester, for multi-cycle core variants where instruction and data memory are a single array. Accepts one request per transaction over a req/gnt handshake, drives the memory port, and returns read data or a write acknowledge to the owner after a fixed memory latency. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- XLEN, 32, address/data width (from `Parameters.vh`)
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal 1..4
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins; legal 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  XLEN  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store ack, one-cycle pulse
- d_rdata  out  XLEN  load data
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid MEM_LATENCY cycles after mem_en

## Operation
- States: IDLE, WAIT. One transaction outstanding at most.
- IDLE, no request: all outputs 0.
- IDLE, request present: pick winner; assert winner's gnt and mem_en combinationally in same cycle; mem_we/addr/wdata muxed from winner (mem_we = 0, mem_wdata = 0 for fetch); register owner; load latency counter with MEM_LATENCY; go WAIT.
- Winner: d_req alone → data; if_req alone → fetch; both → data, unless starve count == STARVE_LIMIT → fetch.
- Starve count: +1 on each IDLE grant cycle where if_req = 1 and data wins; cleared when fetch is granted or if_req = 0 in IDLE; saturates at STARVE_LIMIT.
- WAIT: counter decrements each cycle; when it reaches 1 the owner's rvalid pulses, its rdata = mem_rdata (stores: rdata = 0), FSM returns to IDLE. No gnt, no mem_en in WAIT.
- Non-owner rvalid/rdata always 0.
- Requester changing req/fields before gnt: undefined; after gnt may drop or present next request.
- Reset asserted mid-transaction: state → IDLE, owner cleared, counter and starve count 0; no rvalid is ever produced for the aborted transaction.
- All outputs reset to 0.

## Timing
- Grant in cycle T (IDLE); rvalid in cycle T + MEM_LATENCY; IDLE again in cycle T + MEM_LATENCY + 1, earliest next grant there.
- Throughput: one transaction per MEM_LATENCY + 1 cycles.
- gnt, mem_* combinational from req in IDLE; rvalid registered-state-derived, rdata combinational passthrough of mem_rdata.
- Counter width: $clog2(MEM_LATENCY+1); starve count width 4.

## Structure
- State encoding and owner encoding (OWN_NONE, OWN_IF, OWN_D) as localparams in `Parameters.vh`, shared with future cache/bus blocks.
- One sub-module: mem_arbiter_starve, holding starve count and computing winner from if_req, d_req, starve count; FSM, latency counter, muxes in mem_arbiter.

## Test plan
- MEM_LATENCY=1: if_req, if_addr=0x100, memory returns 0xDEADBEEF → if_gnt and mem_en in T, if_rvalid with if_rdata=0xDEADBEEF in T+1, d_rvalid 0.
- MEM_LATENCY=3: d_req store d_addr=0x40, d_wdata=0x1234 → mem_we=1, mem_wdata=0x1234 in T, d_rvalid in T+3 with d_rdata=0, next grant no earlier than T+4.
- Both held continuously, STARVE_LIMIT=2 → grant order D, D, IF, D, D, IF; starve count clears after each IF grant.
- if_req and d_req together once → data first; if_gnt exactly MEM_LATENCY+1 cycles after d_gnt.
- rst low during WAIT (MEM_LATENCY=3, one cycle after grant) → all outputs 0 immediately, no rvalid after release, new request granted in first IDLE cycle.
- Request asserted during WAIT → no gnt until IDLE; granted in cycle after owner's rvalid.
